// File: rtl/regfile_alu_pkg.sv
// ----------------------------------------------------------------------------
// regfile_alu_pkg
// Shared definitions for the register-file / ALU execute pipeline.
//   - OP_* : ALU operation encodings carried on opsel (codes 10..15 are
//            unused and make the ALU return zero).
//   - sext64 : sign-extends the low 'width' bits of a 64-bit value. Callers
//              zero-extend their field to 64 bits, call this, then size-cast
//              the result to their datapath width (datapaths up to 64 bits).
// ----------------------------------------------------------------------------
package regfile_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    function automatic logic [63:0] sext64(input logic [63:0] value,
                                           input int unsigned width);
        logic [63:0] fill_mask;
        logic        sign;
        // Bits at and above 'width' are replaced by the field's top bit.
        fill_mask = {64{1'b1}} << width;
        sign      = value[6'(width - 1)];
        return (value & ~fill_mask) | (fill_mask & {64{sign}});
    endfunction

endpackage

// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU used by the execute pipeline.
// Ports:
//   a_i      [XLEN-1:0] operand A
//   b_i      [XLEN-1:0] operand B (low clog2(XLEN) bits are the shift amount)
//   opsel_i  [3:0]      operation, encodings from regfile_alu_pkg
//   result_o [XLEN-1:0] result (compares give 0/1, unused codes give 0)
//   zero_o              result == 0
// ----------------------------------------------------------------------------
module alu_core
    import regfile_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      opsel_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    always_comb begin
        result_o = '0;
        case (opsel_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLL:  result_o = a_i << shamt;
            OP_SRL:  result_o = a_i >> shamt;
            OP_SRA:  result_o = $signed(a_i) >>> shamt;
            OP_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/regfile_alu_pipe.sv
// ----------------------------------------------------------------------------
// regfile_alu_pipe
// Two-stage execute unit: RD (operand read from the register file) then
// EX (registered ALU result). Valid/ready handshake on both sides, x0 reads
// as zero and ignores writes, and a read-after-write hazard path.
//
// Build option: define REGFILE_ALU_FORWARD_EN to forward the live ALU result
// into a dependent instruction being accepted (no bubble). Without it, a
// dependent instruction is held off (in_ready low) until the producer has
// left RD and written the register file (one-cycle bubble). Results are the
// same in both builds.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-low reset
//   in_valid   / in_ready   issue handshake
//   rs1, rs2, rd           source / destination register indices
//   opsel      ALU operation
//   use_imm    1: operand B = sign-extended imm_in, 0: operand B = R[rs2]
//   imm_in     immediate
//   reg_write  write the result into rd
//   out_valid  / out_ready  result handshake
//   alu_out    registered result
//   zero_flag  registered (alu_out == 0)
//   out_rd     destination register of the result
// ----------------------------------------------------------------------------
module regfile_alu_pipe
    import regfile_alu_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int IMM_W = 12,
    localparam int RW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RW-1:0]    rs1,
    input  logic [RW-1:0]    rs2,
    input  logic [RW-1:0]    rd,
    input  logic [3:0]       opsel,
    input  logic             use_imm,
    input  logic [IMM_W-1:0] imm_in,
    input  logic             reg_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_out,
    output logic             zero_flag,
    output logic [RW-1:0]    out_rd
);

    // Architectural registers.
    logic [XLEN-1:0] regs_q [NREG];

    // RD stage.
    logic            rd_valid_q, rd_valid_d;
    logic [XLEN-1:0] rd_a_q, rd_a_d;
    logic [XLEN-1:0] rd_b_q, rd_b_d;
    logic [3:0]      rd_op_q, rd_op_d;
    logic [RW-1:0]   rd_rd_q, rd_rd_d;
    logic            rd_we_q, rd_we_d;

    // EX stage.
    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_res_q, ex_res_d;
    logic            ex_zero_q, ex_zero_d;
    logic [RW-1:0]   ex_rd_q, ex_rd_d;

    logic [XLEN-1:0] alu_res;
    logic            alu_zero;
    logic            ex_adv, rd_adv, accept;
    logic            fwd_a, fwd_b;
    logic            rd_write;
    logic [XLEN-1:0] rf_a, rf_b, imm_sext, op_a, op_b;

    // ALU sits between RD and EX: it operates on the RD-stage operands and
    // its result is what EX captures and what the register file receives.
    alu_core #(.XLEN(XLEN)) u_alu (
        .a_i      (rd_a_q),
        .b_i      (rd_b_q),
        .opsel_i  (rd_op_q),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    assign ex_adv   = !ex_valid_q || out_ready;
    assign rd_adv   = rd_valid_q && ex_adv;
    assign accept   = in_valid && in_ready;
    assign rd_write = rd_adv && rd_we_q && (rd_rd_q != '0);

    assign imm_sext = XLEN'(sext64(64'(imm_in), IMM_W));

    assign rf_a = (rs1 == '0) ? '0 : regs_q[rs1];
    assign rf_b = (rs2 == '0) ? '0 : regs_q[rs2];

    // Incoming operand depends on the instruction currently in RD, which
    // has not yet written the register file.
    assign fwd_a = rd_valid_q && rd_we_q && (rd_rd_q != '0) && (rs1 == rd_rd_q);
    assign fwd_b = rd_valid_q && rd_we_q && (rd_rd_q != '0) && !use_imm
                   && (rs2 == rd_rd_q);

`ifdef REGFILE_ALU_FORWARD_EN
    // With RD occupied, accept implies rd_adv, so alu_res is exactly the
    // value being written to rd_rd_q on this edge.
    assign op_a     = fwd_a ? alu_res : rf_a;
    assign op_b     = use_imm ? imm_sext : (fwd_b ? alu_res : rf_b);
    assign in_ready = !rd_valid_q || rd_adv;
`else
    // Hold the dependent instruction until the producer has left RD; the
    // register file then holds the new value.
    assign op_a     = rf_a;
    assign op_b     = use_imm ? imm_sext : rf_b;
    assign in_ready = (!rd_valid_q || rd_adv) && !(fwd_a || fwd_b);
`endif

    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_a_d     = rd_a_q;
        rd_b_d     = rd_b_q;
        rd_op_d    = rd_op_q;
        rd_rd_d    = rd_rd_q;
        rd_we_d    = rd_we_q;
        if (accept) begin
            rd_valid_d = 1'b1;
            rd_a_d     = op_a;
            rd_b_d     = op_b;
            rd_op_d    = opsel;
            rd_rd_d    = rd;
            rd_we_d    = reg_write;
        end else if (rd_adv) begin
            rd_valid_d = 1'b0;
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_res_d   = ex_res_q;
        ex_zero_d  = ex_zero_q;
        ex_rd_d    = ex_rd_q;
        if (rd_adv) begin
            ex_valid_d = 1'b1;
            ex_res_d   = alu_res;
            ex_zero_d  = alu_zero;
            ex_rd_d    = rd_rd_q;
        end else if (out_ready) begin
            // Result consumed and nothing new arriving: EX empties, the
            // data fields simply hold their last value.
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            rd_op_q    <= '0;
            rd_rd_q    <= '0;
            rd_we_q    <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_res_q   <= '0;
            ex_zero_q  <= 1'b1;
            ex_rd_q    <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            rd_op_q    <= rd_op_d;
            rd_rd_q    <= rd_rd_d;
            rd_we_q    <= rd_we_d;
            ex_valid_q <= ex_valid_d;
            ex_res_q   <= ex_res_d;
            ex_zero_q  <= ex_zero_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

    // One register per generate instance. rd_write already excludes x0, so
    // entry 0 stays zero after reset.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        always_ff @(posedge clk) begin
            if (!reset) begin
                regs_q[gi] <= '0;
            end else if (rd_write && (rd_rd_q == RW'(gi))) begin
                regs_q[gi] <= alu_res;
            end
        end
    end

    assign out_valid = ex_valid_q;
    assign alu_out   = ex_res_q;
    assign zero_flag = ex_zero_q;
    assign out_rd    = ex_rd_q;

endmodule
